// File: rtl/jt10_adpcm_pkg.sv
// Shared constants and helpers for the ADPCM mixer/interpolator: width derivation,
// reciprocal step multipliers and signed saturation limits.
package jt10_adpcm_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Accumulator width: input width, growth for NCH summed channels, and one guard bit
   function automatic int acc_width(input int in_w, input int nch);
      return in_w + clog2(nch) + 1;
   endfunction

   // round(65536/INTERP) for INTERP = 1..16
   localparam int RECIP_TBL [16] = '{65536, 32768, 21845, 16384, 13107, 10923, 9362, 8192,
                                     7282, 6554, 5958, 5461, 5041, 4681, 4369, 4096};

   function automatic int recip_of(input int interp);
      return RECIP_TBL[interp-1];
   endfunction

   function automatic longint sat_hi(input int w);
      return (64'sd1 <<< (w-1)) - 64'sd1;
   endfunction

   function automatic longint sat_lo(input int w);
      return -(64'sd1 <<< (w-1));
   endfunction

endpackage

// File: rtl/jt10_adpcm_sat.sv
// Signed clamp from a wide interpolator value down to the output width, with a
// flag raised whenever the value had to be limited.
module jt10_adpcm_sat
   import jt10_adpcm_pkg::*;
#(
   parameter int IW = 21,
   parameter int OW = 16
)(
   input  logic signed [IW-1:0] din,
   output logic signed [OW-1:0] dout,
   output logic                 sat
);

   localparam logic signed [IW-1:0] HI = IW'(sat_hi(OW));
   localparam logic signed [IW-1:0] LO = IW'(sat_lo(OW));

   always_comb begin
      dout = OW'(din);
      sat  = 1'b0;
      if (din > HI) begin
         dout = OW'(HI);
         sat  = 1'b1;
      end else if (din < LO) begin
         dout = OW'(LO);
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/jt10_adpcm_interp.sv
// ADPCM channel mixer with linear interpolation between consecutive frame sums.
// Optional peak meter when JT10_ADPCM_PEAK_EN is defined.
module jt10_adpcm_interp
   import jt10_adpcm_pkg::*;
#(
   parameter int NCH    = 6,
   parameter int IN_W   = 16,
   parameter int OUT_W  = 16,
   parameter int INTERP = 3,
   parameter int RECIP  = 21845
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen,
   input  logic             ch_first,
   input  logic             match,
   input  logic             en_sum,
   input  logic [IN_W-1:0]  pcm_in,
   input  logic             frame,
   input  logic             tick,
`ifdef JT10_ADPCM_PEAK_EN
   input  logic             peak_clr,
   output logic [OUT_W-1:0] peak,
`endif
   output logic [OUT_W-1:0] pcm_out,
   output logic             pcm_valid,
   output logic             sat
);

   localparam int ACC_W  = acc_width(IN_W, NCH);
   localparam int STEP_W = ACC_W + 1;
   localparam int PROD_W = STEP_W + 18;
   localparam int PH_W   = clog2(INTERP + 1);
   // phase reaches INTERP after the last interpolated tick and then holds
   localparam logic [PH_W-1:0] PH_END = PH_W'(INTERP);

   logic signed [ACC_W-1:0]  acc_reg, last_reg, prev_reg, x;
   logic signed [STEP_W-1:0] step_reg, pcm_full_reg, diff, step_next;
   logic signed [PROD_W-1:0] prod;
   logic [PH_W-1:0]          phase_reg;
   logic                     tick_d_reg;
   logic signed [OUT_W-1:0]  sat_out;
   logic                     sat_flag;

   assign x    = en_sum ? ACC_W'($signed(pcm_in)) : '0;
   assign diff = STEP_W'(acc_reg) - STEP_W'(last_reg);
   assign prod = PROD_W'(diff) * PROD_W'($signed({1'b0, 17'(RECIP)}));
   // Arithmetic shift floors the step toward -inf
   assign step_next = STEP_W'(prod >>> 16);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg      <= '0;
         last_reg     <= '0;
         prev_reg     <= '0;
         step_reg     <= '0;
         pcm_full_reg <= '0;
         phase_reg    <= '0;
      end else if (cen) begin
         if (match)
            acc_reg <= ch_first ? x : acc_reg + x;
         if (frame) begin
            prev_reg <= last_reg;
            last_reg <= acc_reg;
            step_reg <= step_next;
         end
         if (tick) begin
            // A coincident frame restarts interpolation from the new prev (old last)
            if (frame || phase_reg == '0) begin
               pcm_full_reg <= STEP_W'(frame ? last_reg : prev_reg);
               phase_reg    <= PH_W'(1);
            end else if (phase_reg != PH_END) begin
               pcm_full_reg <= pcm_full_reg + step_reg;
               phase_reg    <= phase_reg + PH_W'(1);
            end
         end else if (frame) begin
            phase_reg <= '0;
         end
      end
   end

   jt10_adpcm_sat #(
      .IW (STEP_W),
      .OW (OUT_W)
   ) u_sat (
      .din  (pcm_full_reg),
      .dout (sat_out),
      .sat  (sat_flag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_d_reg <= 1'b0;
         pcm_valid  <= 1'b0;
         sat        <= 1'b0;
         pcm_out    <= '0;
      end else begin
         tick_d_reg <= cen & tick;
         pcm_valid  <= tick_d_reg;
         sat        <= tick_d_reg & sat_flag;
         if (tick_d_reg)
            pcm_out <= sat_out;
      end
   end

`ifdef JT10_ADPCM_PEAK_EN
   logic [OUT_W-1:0] mag;

   // Magnitude of the most negative code is clamped to the positive limit
   always_comb begin
      mag = pcm_out;
      if (pcm_out[OUT_W-1])
         mag = (pcm_out == {1'b1, {(OUT_W-1){1'b0}}}) ? {1'b0, {(OUT_W-1){1'b1}}} : -pcm_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         peak <= '0;
      else if (cen && peak_clr)
         peak <= '0;
      else if (pcm_valid && mag > peak)
         peak <= mag;
   end
`endif

endmodule

// File: tb/tb_jt10_adpcm_interp.sv
// Bench for the ADPCM interpolator: directed cases plus randomized frames checked
// against a per-tick closed-form model (prev + k*step, k capped at INTERP-1).
module tb_jt10_adpcm_interp;

   localparam int  INTERP = 3;
   localparam longint RECIP = 21845;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, cen, ch_first, match, en_sum, frame, tick;
   logic [15:0] pcm_in, pcm_out;
   logic        pcm_valid, sat;

   logic        cen1, first1, match1, en1, frame1, tick1;
   logic [15:0] pcm_in1, pcm_out1;
   logic        valid1, sat1;

   int vectors = 0;
   int miscompares = 0;

   longint m_acc = 0, m_last = 0, m_prev = 0, m_step = 0;
   int     m_ticks = 0;
   bit     pend_v = 0, pend_sat = 0;
   longint pend_val = 0, out_hold = 0;

   jt10_adpcm_interp #(.NCH(6), .IN_W(16), .OUT_W(16), .INTERP(3), .RECIP(21845)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .ch_first(ch_first), .match(match),
      .en_sum(en_sum), .pcm_in(pcm_in), .frame(frame), .tick(tick),
      .pcm_out(pcm_out), .pcm_valid(pcm_valid), .sat(sat)
   );

   jt10_adpcm_interp #(.NCH(1), .IN_W(16), .OUT_W(16), .INTERP(1), .RECIP(65536)) dut1 (
      .clk(clk), .rst_n(rst_n), .cen(cen1), .ch_first(first1), .match(match1),
      .en_sum(en1), .pcm_in(pcm_in1), .frame(frame1), .tick(tick1),
      .pcm_out(pcm_out1), .pcm_valid(valid1), .sat(sat1)
   );

   task automatic chk(input string tag, input logic signed [39:0] got, input logic signed [39:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_last = 0; m_prev = 0; m_step = 0; m_ticks = 0;
      pend_v = 0; pend_sat = 0; pend_val = 0; out_hold = 0;
   endtask

   // One clock of stimulus on the main DUT; checks outputs produced by the previous cycle's tick
   task automatic cyc(input bit c, input bit f, input bit t, input bit m, input bit first,
                      input bit en, input logic [15:0] d);
      bit nv, nsat;
      longint nval, x, v;
      int k;
      nv = 0; nsat = 0; nval = 0;
      if (c) begin
         if (f) begin
            m_prev  = m_last;
            m_last  = m_acc;
            m_step  = ((m_last - m_prev) * RECIP) >>> 16;
            m_ticks = 0;
         end
         if (m) begin
            x = en ? longint'($signed(d)) : 0;
            m_acc = first ? x : m_acc + x;
         end
         if (t) begin
            k = (m_ticks < INTERP-1) ? m_ticks : INTERP-1;
            v = m_prev + k * m_step;
            m_ticks++;
            nv   = 1;
            nsat = (v > 32767) || (v < -32768);
            nval = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
         end
      end
      cen = c; frame = f; tick = t; match = m; ch_first = first; en_sum = en; pcm_in = d;
      @(posedge clk); #1;
      chk("valid", pcm_valid, pend_v);
      if (pend_v) out_hold = pend_val;
      chk("out", $signed(pcm_out), out_hold);
      chk("sat", sat, pend_v & pend_sat);
      pend_v = nv; pend_val = nval; pend_sat = nsat;
      cen = 1; frame = 0; tick = 0; match = 0; ch_first = 0; en_sum = 0; pcm_in = 16'h0;
   endtask

   task automatic idle();
      cyc(1, 0, 0, 0, 0, 0, 16'h0);
   endtask

   task automatic six(input logic [15:0] d);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, i == 0, 1, d);
   endtask

   task automatic tick_chk(input string tag, input longint exp, input bit exp_sat);
      cyc(1, 0, 1, 0, 0, 0, 16'h0);
      idle();
      chk(tag, $signed(pcm_out), exp);
      chk({tag, "_sat"}, sat, exp_sat);
   endtask

   task automatic cyc2(input bit m, input bit f, input bit t, input logic [15:0] d);
      cen1 = 1; match1 = m; first1 = m; en1 = 1; frame1 = f; tick1 = t; pcm_in1 = d;
      @(posedge clk); #1;
      cen1 = 0; match1 = 0; first1 = 0; en1 = 0; frame1 = 0; tick1 = 0; pcm_in1 = 16'h0;
   endtask

   initial begin
      logic [15:0] v2;
      longint exp2;
      rst_n = 0; cen = 0; ch_first = 0; match = 0; en_sum = 0; frame = 0; tick = 0; pcm_in = 0;
      cen1 = 0; first1 = 0; match1 = 0; en1 = 0; frame1 = 0; tick1 = 0; pcm_in1 = 0;
      #1;
      chk("rst_out", $signed(pcm_out), 0);
      chk("rst_valid", pcm_valid, 0);
      chk("rst_sat", sat, 0);
      chk("rst_out1", $signed(pcm_out1), 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1;
      model_reset();

      // 1: 0x1000 on all channels
      six(16'h1000); cyc(1, 1, 0, 0, 0, 0, 16'h0);
      tick_chk("t1_p0", 0, 0); tick_chk("t1_p1", 8191, 0); tick_chk("t1_p2", 16382, 0);
      six(16'h1000); cyc(1, 1, 0, 0, 0, 0, 16'h0);
      tick_chk("t1_q0", 24576, 0); tick_chk("t1_q1", 24576, 0); tick_chk("t1_q2", 24576, 0);

      // 2: only channel 0 enabled
      cyc(1, 0, 0, 1, 1, 1, 16'h0400);
      for (int i = 1; i < 6; i++) cyc(1, 0, 0, 1, 0, 0, 16'(16'h1234 * i));
      cyc(1, 1, 0, 0, 0, 0, 16'h0);
      tick_chk("t2_p0", 24576, 0); tick_chk("t2_p1", 16725, 0); tick_chk("t2_p2", 8874, 0);

      // 3: positive and negative saturation
      six(16'h7000); cyc(1, 1, 0, 0, 0, 0, 16'h0);
      six(16'h7000); cyc(1, 1, 0, 0, 0, 0, 16'h0);
      tick_chk("t3_pos", 32767, 1);
      six(16'h9000); cyc(1, 1, 0, 0, 0, 0, 16'h0);
      six(16'h9000); cyc(1, 1, 0, 0, 0, 0, 16'h0);
      tick_chk("t3_neg", -32768, 1);

      // 4: more ticks than INTERP hold the final phase
      six(16'h0000); cyc(1, 1, 0, 0, 0, 0, 16'h0);
      six(16'h0300); cyc(1, 1, 0, 0, 0, 0, 16'h0);
      tick_chk("t4_p0", 0, 0); tick_chk("t4_p1", 1535, 0); tick_chk("t4_p2", 3070, 0);
      tick_chk("t4_p3", 3070, 0); tick_chk("t4_p4", 3070, 0);

      // 5: frame, tick and match in one cycle
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, i == 0, 1, 16'h0100);
      cyc(1, 1, 1, 1, 0, 1, 16'h0100);
      idle();
      chk("t5_out", $signed(pcm_out), 4608);
      tick_chk("t5_p1", 4608 + (((1280 - 4608) * RECIP) >>> 16), 0);

      // Randomized frames with occasional cen-low cycles carrying junk inputs
      for (int f = 0; f < 40; f++) begin
         bit fdone;
         fdone = 0;
         for (int s = 0; s < 6; s++) begin
            if ($urandom_range(0, 5) == 0)
               cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 16'($urandom));
            if (s == 5 && $urandom_range(0, 3) == 0) fdone = 1;
            cyc(1, fdone, $urandom_range(0, 2) == 0, 1, s == 0, $urandom_range(0, 4) != 0,
                16'($urandom_range(0, 65535)));
         end
         if (!fdone) cyc(1, 1, $urandom_range(0, 2) == 0, 0, 0, 0, 16'h0);
         for (int i = 0; i < 3; i++) cyc(1, 0, $urandom_range(0, 1) == 1, 0, 0, 0, 16'h0);
      end

      // 6: async reset mid-frame discards partial sums and pending output
      cyc(1, 0, 0, 1, 1, 1, 16'h2345);
      cyc(1, 0, 1, 1, 0, 1, 16'h1111);
      @(negedge clk); rst_n = 0; #1;
      chk("mrst_out", $signed(pcm_out), 0);
      chk("mrst_valid", pcm_valid, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1;
      model_reset();
      idle(); idle();
      cyc(1, 1, 0, 0, 0, 0, 16'h0);
      tick_chk("mrst_p0", 0, 0);
      six(16'h0200); cyc(1, 1, 0, 0, 0, 0, 16'h0);
      tick_chk("mrst_p1", 0, 0);
      tick_chk("mrst_p2", 1023, 0);

      // INTERP=1, NCH=1 build: pass-through, one frame late
      exp2 = 0;
      for (int i = 0; i < 8; i++) begin
         v2 = 16'($urandom);
         cyc2(1, 0, 0, v2);
         cyc2(0, 1, 0, 16'h0);
         cyc2(0, 0, 1, 16'h0);
         cyc2(0, 0, 0, 16'h0);
         chk("p1_valid", valid1, 1);
         chk("p1_out", $signed(pcm_out1), exp2);
         chk("p1_sat", sat1, 0);
         exp2 = longint'($signed(v2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
